// File: rtl/hilo_pair.sv
// HI/LO register pair with prioritised multi-channel writes and 2-cycle MADD/MSUB.
// Define HILO_BYPASS_EN to forward plain-write data to hi_o/lo_o in the accept cycle.
module hilo_pair #(
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [3*NUM_WR-1:0]        wr_op,
  input  logic [2*DATA_W*NUM_WR-1:0] wr_data,
  output logic                       wr_ready,
  output logic                       busy,
  output logic [DATA_W-1:0]          hi_o,
  output logic [DATA_W-1:0]          lo_o,
  output logic                       wr_collide
);

  localparam logic [2:0] OP_WHI   = 3'd0;
  localparam logic [2:0] OP_WLO   = 3'd1;
  localparam logic [2:0] OP_WBOTH = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MSUB  = 3'd4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic              carry_q, carry_d;
  logic              collide_q, collide_d;

  logic [2:0]        win_op;
  logic [DATA_W-1:0] win_hi;
  logic [DATA_W-1:0] win_lo;
  logic              seen;
  logic              multi;
  logic              accept;
  logic              sub;
  logic [DATA_W-1:0] opnd_lo;
  logic [DATA_W:0]   sum;

  // Later channels overwrite earlier ones, so the highest index wins.
  always_comb begin
    win_op = '0;
    win_hi = '0;
    win_lo = '0;
    seen   = 1'b0;
    multi  = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) begin
        win_op = wr_op[3*i +: 3];
        win_hi = wr_data[2*DATA_W*i+DATA_W +: DATA_W];
        win_lo = wr_data[2*DATA_W*i +: DATA_W];
        multi  = multi | seen;
        seen   = 1'b1;
      end
    end
  end

  assign busy     = (state_q == ST_ACC);
  assign wr_ready = ~busy;
  assign accept   = wr_ready & seen;
  assign sub      = (win_op == OP_MSUB);
  assign opnd_lo  = sub ? ~win_lo : win_lo;
  assign sum      = {1'b0, lo_q} + {1'b0, opnd_lo}
                  + {{DATA_W{1'b0}}, sub};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    carry_d   = carry_q;
    collide_d = accept & multi;
    if (state_q == ST_ACC) begin
      hi_d    = hi_q + acc_hi_q + {{(DATA_W-1){1'b0}}, carry_q};
      state_d = ST_IDLE;
    end else if (accept) begin
      unique case (1'b1)
        (win_op == OP_WHI):   hi_d = win_hi;
        (win_op == OP_WLO):   lo_d = win_lo;
        (win_op == OP_WBOTH): begin
          hi_d = win_hi;
          lo_d = win_lo;
        end
        (win_op == OP_MADD),
        (win_op == OP_MSUB): begin
          lo_d     = sum[DATA_W-1:0];
          carry_d  = sum[DATA_W];
          acc_hi_d = sub ? ~win_hi : win_hi;
          state_d  = ST_ACC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      carry_q   <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      carry_q   <= carry_d;
      collide_q <= collide_d;
    end
  end

  assign wr_collide = collide_q;

`ifdef HILO_BYPASS_EN
  // accept already excludes busy, so forwarding never leaks during ACC.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (accept && (win_op == OP_WHI || win_op == OP_WBOTH))
      hi_o = win_hi;
    if (accept && (win_op == OP_WLO || win_op == OP_WBOTH))
      lo_o = win_lo;
  end
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_pair.sv
// Directed self-checking bench for hilo_pair (DATA_W=32, NUM_WR=2).
// Inputs change 1ns after a rising edge; outputs sampled at the same point.
module tb_hilo_pair;

  localparam int DW = 32;
  localparam int NW = 2;

  logic              clk;
  logic              reset;
  logic [NW-1:0]     wr_en;
  logic [3*NW-1:0]   wr_op;
  logic [2*DW*NW-1:0] wr_data;
  logic              wr_ready;
  logic              busy;
  logic [DW-1:0]     hi_o;
  logic [DW-1:0]     lo_o;
  logic              wr_collide;

  int n_chk;
  int n_fail;

  hilo_pair #(.DATA_W(DW), .NUM_WR(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_op     (wr_op),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .wr_collide(wr_collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [2:0] op,
                        input logic [DW-1:0] dh, input logic [DW-1:0] dl);
    wr_en[ch]              = 1'b1;
    wr_op[3*ch +: 3]       = op;
    wr_data[2*DW*ch +: 2*DW] = {dh, dl};
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_op   = '0;
    wr_data = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_chk++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h_%h want 0_0", hi_o, lo_o);
    end
    n_chk++;
    if (busy !== 1'b0 || wr_ready !== 1'b1 || wr_collide !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: busy=%b rdy=%b col=%b want 0 1 0",
               busy, wr_ready, wr_collide);
    end
  endtask

  task automatic test_collide();
    idle();
    set_ch(0, 3'd2, 32'h11111111, 32'h22222222);
    set_ch(1, 3'd1, 32'h0, 32'hAAAAAAAA);
`ifdef HILO_BYPASS_EN
    #1;
    n_chk++;
    if (lo_o !== 32'hAAAAAAAA || hi_o !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_lo: got %h_%h want 0_aaaaaaaa", hi_o, lo_o);
    end
`endif
    tick();
    idle();
    n_chk++;
    if (hi_o !== 32'h0 || lo_o !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL prio_write: got %h_%h want 00000000_aaaaaaaa", hi_o, lo_o);
    end
    n_chk++;
    if (wr_collide !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set: got %b want 1", wr_collide);
    end
    tick();
    n_chk++;
    if (wr_collide !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_pulse: got %b want 0", wr_collide);
    end
  endtask

  task automatic test_plain();
    idle();
    set_ch(0, 3'd0, 32'hDEADBEEF, 32'h12345678);
    tick();
    n_chk++;
    if (hi_o !== 32'hDEADBEEF || lo_o !== 32'hAAAAAAAA || wr_collide !== 1'b0) begin
      n_fail++;
      $display("FAIL whi: got %h_%h col=%b want deadbeef_aaaaaaaa 0",
               hi_o, lo_o, wr_collide);
    end
    idle();
    set_ch(1, 3'd1, 32'h0, 32'h0BADF00D);
    tick();
    n_chk++;
    if (hi_o !== 32'hDEADBEEF || lo_o !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL wlo_b2b: got %h_%h want deadbeef_0badf00d", hi_o, lo_o);
    end
    idle();
    set_ch(1, 3'd5, 32'h1, 32'h1);
    tick();
    n_chk++;
    if (hi_o !== 32'hDEADBEEF || lo_o !== 32'h0BADF00D || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_op: got %h_%h busy=%b want deadbeef_0badf00d 0",
               hi_o, lo_o, busy);
    end
    idle();
  endtask

  task automatic test_madd();
    idle();
    set_ch(0, 3'd2, 32'h0, 32'hFFFFFFFF);
    tick();
    set_ch(0, 3'd3, 32'h0, 32'h1);
    tick();
    idle();
    n_chk++;
    if (lo_o !== 32'h0 || hi_o !== 32'h0 || busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL madd_n: got %h_%h busy=%b rdy=%b want 0_0 1 0",
               hi_o, lo_o, busy, wr_ready);
    end
    tick();
    n_chk++;
    if (hi_o !== 32'h1 || lo_o !== 32'h0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL madd_n1: got %h_%h busy=%b rdy=%b want 1_0 0 1",
               hi_o, lo_o, busy, wr_ready);
    end
    set_ch(1, 3'd2, 32'h00000001, 32'h80000000);
    tick();
    set_ch(1, 3'd3, 32'hFFFFFFFF, 32'h80000000);
    tick();
    idle();
    tick();
    n_chk++;
    if (hi_o !== 32'h1 || lo_o !== 32'h0) begin
      n_fail++;
      $display("FAIL madd_wrap: got %h_%h want 00000001_00000000", hi_o, lo_o);
    end
  endtask

  task automatic test_msub();
    idle();
    set_ch(0, 3'd2, 32'h0, 32'h0);
    tick();
    set_ch(0, 3'd4, 32'h0, 32'h1);
    tick();
    idle();
    n_chk++;
    if (lo_o !== 32'hFFFFFFFF || hi_o !== 32'h0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL msub_n: got %h_%h busy=%b want 0_ffffffff 1",
               hi_o, lo_o, busy);
    end
    tick();
    n_chk++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL msub_n1: got %h_%h busy=%b want ffffffff_ffffffff 0",
               hi_o, lo_o, busy);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    set_ch(0, 3'd2, 32'h0, 32'h0);
    tick();
    set_ch(0, 3'd3, 32'h2, 32'h3);
    tick();
    idle();
    set_ch(0, 3'd0, 32'h7, 32'h0);
    set_ch(1, 3'd0, 32'h5, 32'h0);
    tick();
    n_chk++;
    if (hi_o !== 32'h2 || lo_o !== 32'h3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: got %h_%h busy=%b want 2_3 0",
               hi_o, lo_o, busy);
    end
    n_chk++;
    if (wr_collide !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_nocollide: got %b want 0", wr_collide);
    end
    tick();
    idle();
    n_chk++;
    if (hi_o !== 32'h5 || lo_o !== 32'h3 || wr_collide !== 1'b1) begin
      n_fail++;
      $display("FAIL held_whi: got %h_%h col=%b want 5_3 1",
               hi_o, lo_o, wr_collide);
    end
  endtask

  task automatic test_reset_acc();
    idle();
    set_ch(0, 3'd2, 32'h1, 32'h2);
    tick();
    set_ch(0, 3'd3, 32'h1, 32'h1);
    tick();
    idle();
    n_chk++;
    if (busy !== 1'b1 || lo_o !== 32'h3) begin
      n_fail++;
      $display("FAIL racc_pre: busy=%b lo=%h want 1 3", busy, lo_o);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL racc_clear: got %h_%h busy=%b rdy=%b want 0_0 0 1",
               hi_o, lo_o, busy, wr_ready);
    end
    #1 reset = 1'b1;
    tick();
    n_chk++;
    if (hi_o !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL racc_discard: hi=%h busy=%b want 0 0", hi_o, busy);
    end
    set_ch(1, 3'd2, 32'h00001234, 32'h00005678);
    tick();
    idle();
    n_chk++;
    if (hi_o !== 32'h00001234 || lo_o !== 32'h00005678) begin
      n_fail++;
      $display("FAIL racc_after: got %h_%h want 00001234_00005678", hi_o, lo_o);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_collide();
    test_plain();
    test_madd();
    test_msub();
    test_back_to_back();
    test_reset_acc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_pair.md
# hilo_pair

Parametrised HI/LO register pair for the execute/write-back boundary of the dual-issue MIPS core. It accepts writes from NUM_WR issue channels, with the highest-indexed active channel winning. It supports single-half, full-pair and two-cycle accumulate (MADD/MSUB style) updates. The block presents HI and LO to the bypass network and provides a ready/busy handshake for the accumulate sequence.

## Interface
Parameters:
- DATA_W, 32: width of each of HI and LO.
- NUM_WR, 2: number of write channels; channel NUM_WR-1 has highest priority.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- wr_en  in  NUM_WR  per-channel write request.
- wr_op  in  3*NUM_WR  per-channel opcode; channel i at bits [3i+2:3i]. Values: 0 WHI, 1 WLO, 2 WBOTH, 3 MADD, 4 MSUB; 5-7 are no-op.
- wr_data  in  2*DATA_W*NUM_WR  per-channel operand {hi,lo}; channel i at bits [2*DATA_W*(i+1)-1 : 2*DATA_W*i].
- wr_ready  out  1  =~busy; requests are accepted only when high.
- busy  out  1  high during the second cycle of an accumulate.
- hi_o  out  DATA_W  HI value.
- lo_o  out  DATA_W  LO value.
- wr_collide  out  1  registered pulse; set when an accepted cycle had more than one wr_en set.

## Operation
- Reset values: HI=0, LO=0, busy=0, wr_ready=1, wr_collide=0, internal carry and operand latches=0.
- Arbitration: on a ready cycle, the highest i with wr_en[i]=1 is the winner. Its op and data are used; all other channels are dropped, not queued.
- WHI: HI<=data_hi; LO unchanged.
- WLO: LO<=data_lo; HI unchanged.
- WBOTH: HI<=data_hi and LO<=data_lo in the same edge.
- Op codes 5-7: no state change.
- MADD/MSUB FSM states:
  - IDLE -> ACC on an accepted MADD/MSUB.
  - ACC -> IDLE unconditionally after one cycle.
- Accept edge (IDLE->ACC):
  - MADD: {c,LO}<=LO+data_lo.
  - MSUB: {c,LO}<=LO+~data_lo+1.
  - Latch the high operand (data_hi, or ~data_hi for MSUB) and carry c.
- ACC edge: HI<=HI+latched_hi+c (DATA_W-bit, carry-out discarded).
- Net result: {HI,LO} += / -= {data_hi,data_lo}, modulo 2^(2*DATA_W). No overflow flag.
- While busy=1, all wr_en are ignored and no collision is flagged. Senders hold requests until wr_ready=1.
- reset asserted at any time, including in ACC: returns to IDLE immediately with all state cleared. The partial accumulate is discarded.

## Timing
- Plain writes: accepted at edge N; visible on hi_o/lo_o after edge N (one-cycle latency, without bypass).
- Accumulate: accepted at edge N; LO final after edge N. busy=1 and wr_ready=0 between edges N and N+1. HI final after edge N+1, when busy returns to 0.
- Back-to-back: a new request may be accepted at edge N+1 if wr_ready=1 in the cycle before it. Throughput is one accumulate per 2 cycles and one plain write per cycle.
- wr_collide: registered at edge N for the cycle ending at N; held high for one cycle.
- During ACC, hi_o shows the old HI; lo_o shows the new LO.

## Configuration
- HILO_BYPASS_EN defined:
  - hi_o/lo_o combinationally forward the winning channel's WHI/WLO/WBOTH data in the accept cycle (zero-latency read).
  - MADD/MSUB results are never forwarded.
  - The forwarded value is suppressed when busy=1.
- HILO_BYPASS_EN undefined: hi_o/lo_o are pure register outputs.

## Test plan
- Reset then idle -> hi_o=0, lo_o=0, busy=0, wr_ready=1, wr_collide=0.
- ch0 WBOTH {0x11111111,0x22222222} and ch1 WLO 0xAAAAAAAA in the same cycle -> HI=0, LO=0xAAAAAAAA, wr_collide=1 for one cycle. With HILO_BYPASS_EN, lo_o=0xAAAAAAAA in the same cycle.
- HI=0, LO=0xFFFFFFFF, MADD {0x00000000,0x00000001} -> after edge N LO=0, busy=1; after edge N+1 HI=1, busy=0.
- {HI,LO}=0, MSUB {0,1} -> {HI,LO}={0xFFFFFFFF,0xFFFFFFFF} after 2 edges.
- WHI 0x5 held during ACC cycle -> ignored while busy; accepted the next cycle, HI=0x5 one edge later.
- reset pulse during ACC after MADD -> HI=LO=0, busy=0; later writes behave normally.
